// File: rtl/mod_pixel_reader.sv
// Frame-memory pixel reader.
// Fetches a width x height BGR image (three bytes per pixel) from byte-addressed
// memory and presents it as a raster-order pixel stream with sof/eol/eof markers.
//
// Output handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. Once pix_valid is raised it stays high, with pix_data
// and the flags held constant, until that transfer happens.
module mod_pixel_reader #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_in,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t      state_q;
    logic        start_q;
    logic        done_q;
    logic        busy_q;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [15:0] x_q;
    logic [15:0] y_q;

    // Read issue stage: byte index 0=B, 1=G, 2=R of the read on the bus this cycle.
    logic        mem_rd_q;
    logic [31:0] mem_addr_q;
    logic [1:0]  rd_idx_q;

    // Return stage: mem_rdata is valid for the read issued one cycle earlier.
    logic        ret_valid_q;
    logic [1:0]  ret_idx_q;
    logic [2:0]  ret_flags_q;
    logic [7:0]  b_q;
    logic [7:0]  g_q;

    // Pixel FIFO entry layout: {sof, eol, eof, R, G, B}.
    logic [26:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    logic        start_rise;
    logic        push;
    logic        pop;
    logic        rd_last_byte;
    logic        cur_sof;
    logic        cur_eol;
    logic        cur_eof;
    logic        slot_ok;
    logic [AW:0] cnt_after;
    logic [AW:0] asm_after;
    logic [26:0] head;

    assign start_rise   = start & ~start_q;
    assign push         = ret_valid_q && (ret_idx_q == 2'd2);
    assign pop          = pix_valid && pix_ready;
    assign rd_last_byte = mem_rd_q && (rd_idx_q == 2'd2);
    assign head         = fifo_mem_q[rd_ptr_q];

    // Flags and slot accounting for the pixel currently being read.
    always_comb begin
        cur_sof   = (x_q == 16'd0) && (y_q == 16'd0);
        cur_eol   = (x_q == width_q - 16'd1);
        cur_eof   = cur_eol && (y_q == height_q - 16'd1);
        // Occupancy after this edge, plus the pixel whose R byte is still in flight.
        cnt_after = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        asm_after = {{AW{1'b0}}, rd_last_byte};
        slot_ok   = (cnt_after + asm_after) < DEPTH_C;
    end

    // FIFO storage; only written when an R byte completes a pixel.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {ret_flags_q, mem_rdata, g_q, b_q};
        end
    end

    // Control FSM, read pipeline, pixel position and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            rd_idx_q    <= '0;
            ret_valid_q <= 1'b0;
            ret_idx_q   <= '0;
            ret_flags_q <= '0;
            b_q         <= '0;
            g_q         <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            start_q     <= start;
            ret_valid_q <= mem_rd_q;
            ret_idx_q   <= rd_idx_q;

            if (ret_valid_q && ret_idx_q == 2'd0) b_q <= mem_rdata;
            if (ret_valid_q && ret_idx_q == 2'd1) g_q <= mem_rdata;

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_after;

            // Flags travel with the R read; position advances once per pixel.
            if (rd_last_byte) begin
                ret_flags_q <= {cur_sof, cur_eol, cur_eof};
                if (cur_eol) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    mem_rd_q <= 1'b0;
                    if (start_rise) begin
                        width_q  <= width;
                        height_q <= height;
                        x_q      <= '0;
                        y_q      <= '0;
                        if (width == 16'd0 || height == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            busy_q     <= 1'b1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= addr_in;
                            rd_idx_q   <= 2'd0;
                        end
                    end
                end
                FETCH: begin
                    if (mem_rd_q && rd_idx_q != 2'd2) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + 32'd1;
                        rd_idx_q   <= rd_idx_q + 2'd1;
                    end else if (rd_last_byte && cur_eof) begin
                        state_q  <= DRAIN;
                        mem_rd_q <= 1'b0;
                    end else if (slot_ok) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + 32'd1;
                        rd_idx_q   <= 2'd0;
                    end else begin
                        mem_rd_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    mem_rd_q <= 1'b0;
                    if (pop && head[24]) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    mem_rd_q <= 1'b0;
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign pix_valid = (cnt_q != '0);
    assign pix_data  = pix_valid ? head[23:0] : 24'd0;
    assign pix_sof   = pix_valid & head[26];
    assign pix_eol   = pix_valid & head[25];
    assign pix_eof   = pix_valid & head[24];

endmodule
